// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat deal sequencer and its score logic.
// Rank encoding: 0 = no card, 1..13 = A..K.
package baccarat_pkg;

   typedef enum logic [2:0] {
      DEAL_P1,
      DEAL_B1,
      DEAL_P2,
      DEAL_B2,
      DECIDE,
      BANK3,
      RESULT,
      DONE
   } deal_state_t;

   localparam logic [3:0] CARD_NONE = 4'd0;
   localparam logic [3:0] CARD_MIN  = 4'd1;
   localparam logic [3:0] CARD_MAX  = 4'd13;

   // Baccarat point value of a rank: A..9 count face value, 10/J/Q/K count zero.
   function automatic logic [3:0] card_value(input logic [3:0] rank);
      logic [3:0] value;
      value = 4'd0;
      if (rank >= CARD_MIN && rank <= 4'd9) value = rank;
      return value;
   endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running rank source: cycles 1..13 every clock, restarting at 1 on reset.
module card_counter
   import baccarat_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] card
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   always_comb begin
      count_d = (count_q == CARD_MAX) ? CARD_MIN : count_q + 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) count_q <= CARD_MIN;
      else       count_q <= count_d;
   end

   assign card = count_q;

endmodule

// File: rtl/baccarat_dealer.sv
// Deals one baccarat hand from the rank counter, applies the third-card rules
// using externally computed hand scores, and latches the winner.
module baccarat_dealer
   import baccarat_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic [3:0] pscore,
   input  logic [3:0] bscore,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] bcard1,
   output logic [3:0] bcard2,
   output logic [3:0] bcard3,
   output logic       player_win,
   output logic       banker_win,
   output logic       done
);

   deal_state_t state_q, state_d;
   logic [3:0]  card;
   logic [3:0]  pcard1_q, pcard1_d, pcard2_q, pcard2_d, pcard3_q, pcard3_d;
   logic [3:0]  bcard1_q, bcard1_d, bcard2_q, bcard2_d, bcard3_q, bcard3_d;
   logic        player_win_q, player_win_d;
   logic        banker_win_q, banker_win_d;
   logic        done_q, done_d;

   card_counter u_card_counter (
      .clk   (clk),
      .reset (reset),
      .card  (card)
   );

   // Banker's third-card tableau, given the banker total and the player's third-card value.
   function automatic logic banker_draws(input logic [3:0] bs, input logic [3:0] v);
      logic draw;
      draw = 1'b0;
      case (bs)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (v != 4'd8);
         4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
         4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
         4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
         default:          draw = 1'b0;
      endcase
      return draw;
   endfunction

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
      state_d      = state_q;
      pcard1_d     = pcard1_q;
      pcard2_d     = pcard2_q;
      pcard3_d     = pcard3_q;
      bcard1_d     = bcard1_q;
      bcard2_d     = bcard2_q;
      bcard3_d     = bcard3_q;
      player_win_d = player_win_q;
      banker_win_d = banker_win_q;
      done_d       = done_q;

      case (state_q)
         DEAL_P1: if (step) begin pcard1_d = card; state_d = DEAL_B1; end
         DEAL_B1: if (step) begin bcard1_d = card; state_d = DEAL_P2; end
         DEAL_P2: if (step) begin pcard2_d = card; state_d = DEAL_B2; end
         DEAL_B2: if (step) begin bcard2_d = card; state_d = DECIDE;  end
         DECIDE: begin
            if (step) begin
               if (pscore >= 4'd8 || bscore >= 4'd8) begin
                  state_d = RESULT;
               end else if (pscore <= 4'd5) begin
                  pcard3_d = card;
                  state_d  = BANK3;
               end else begin
                  if (bscore <= 4'd5) bcard3_d = card;
                  state_d = RESULT;
               end
            end
         end
         BANK3: begin
            if (step) begin
               if (banker_draws(bscore, card_value(pcard3_q))) bcard3_d = card;
               state_d = RESULT;
            end
         end
         // Scores here already reflect the last card loaded on the way in.
         RESULT: begin
            player_win_d = (pscore >= bscore);
            banker_win_d = (bscore >= pscore);
            done_d       = 1'b1;
            state_d      = DONE;
         end
         DONE:    state_d = DONE;
         default: state_d = DEAL_P1;
      endcase
   end

   // NOTE: only control/data flops exist here (no memories), so all of them take the reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= DEAL_P1;
         pcard1_q     <= CARD_NONE;
         pcard2_q     <= CARD_NONE;
         pcard3_q     <= CARD_NONE;
         bcard1_q     <= CARD_NONE;
         bcard2_q     <= CARD_NONE;
         bcard3_q     <= CARD_NONE;
         player_win_q <= 1'b0;
         banker_win_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pcard1_q     <= pcard1_d;
         pcard2_q     <= pcard2_d;
         pcard3_q     <= pcard3_d;
         bcard1_q     <= bcard1_d;
         bcard2_q     <= bcard2_d;
         bcard3_q     <= bcard3_d;
         player_win_q <= player_win_d;
         banker_win_q <= banker_win_d;
         done_q       <= done_d;
      end
   end

   assign pcard1     = pcard1_q;
   assign pcard2     = pcard2_q;
   assign pcard3     = pcard3_q;
   assign bcard1     = bcard1_q;
   assign bcard2     = bcard2_q;
   assign bcard3     = bcard3_q;
   assign player_win = player_win_q;
   assign banker_win = banker_win_q;
   assign done       = done_q;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer: per-cycle vector table with hand-computed
// card/flag expectations, plus a bounded-wait check of the result latency.
module tb_baccarat_dealer;

   logic       clk;
   logic       reset;
   logic       step;
   logic [3:0] pscore, bscore;
   logic [3:0] pcard1, pcard2, pcard3, bcard1, bcard2, bcard3;
   logic       player_win, banker_win, done;

   baccarat_dealer dut (
      .clk        (clk),
      .reset      (reset),
      .step       (step),
      .pscore     (pscore),
      .bscore     (bscore),
      .pcard1     (pcard1),
      .pcard2     (pcard2),
      .pcard3     (pcard3),
      .bcard1     (bcard1),
      .bcard2     (bcard2),
      .bcard3     (bcard3),
      .player_win (player_win),
      .banker_win (banker_win),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       stp;
      logic [3:0] ps;
      logic [3:0] bs;
      logic [26:0] exp_out;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Running expected card/flag values; each table entry snapshots them.
   logic [3:0] x_p1, x_b1, x_p2, x_b2, x_p3, x_b3;
   logic       x_pw, x_bw, x_dn;

   function automatic logic [26:0] outs();
      return {pcard1, bcard1, pcard2, bcard2, pcard3, bcard3, player_win, banker_win, done};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clr();
      {x_p1, x_b1, x_p2, x_b2, x_p3, x_b3} = '0;
      {x_pw, x_bw, x_dn} = '0;
   endtask

   task automatic add(input logic rst, input logic stp, input logic [3:0] ps, input logic [3:0] bs);
      vec_t v;
      v.rst = rst;
      v.stp = stp;
      v.ps  = ps;
      v.bs  = bs;
      v.exp_out = {x_p1, x_b1, x_p2, x_b2, x_p3, x_b3, x_pw, x_bw, x_dn};
      vecs.push_back(v);
   endtask

   // Reset edge followed by four dealing steps; counter is 1 at the first step.
   task automatic reset_and_deal4();
      clr();
      add(1'b1, 1'b0, 4'd0, 4'd0);
      x_p1 = 4'd1; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_b1 = 4'd2; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_p2 = 4'd3; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_b2 = 4'd4; add(1'b0, 1'b1, 4'd0, 4'd0);
   endtask

   task automatic tick(input logic rst, input logic stp, input logic [3:0] ps, input logic [3:0] bs);
      reset  = rst;
      step   = stp;
      pscore = ps;
      bscore = bs;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      reset = 1'b1; step = 1'b0; pscore = '0; bscore = '0;

      // Power-up reset, idle cycles, then a 2-cycle reset mid-stream.
      clr();
      add(1'b1, 1'b0, 4'd0, 4'd0);
      add(1'b0, 1'b0, 4'd0, 4'd0);
      add(1'b0, 1'b0, 4'd0, 4'd0);
      add(1'b1, 1'b0, 4'd0, 4'd0);
      add(1'b1, 1'b0, 4'd0, 4'd0);
      x_p1 = 4'd1; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_b1 = 4'd2; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_p2 = 4'd3; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_b2 = 4'd4; add(1'b0, 1'b1, 4'd0, 4'd0);
      // Natural 8 vs 3: no third cards, player wins; later step ignored.
      add(1'b0, 1'b1, 4'd8, 4'd3);
      x_pw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd8, 4'd3);
      add(1'b0, 1'b1, 4'd8, 4'd3);

      // Player draws an 8 (counter 8 after three held cycles), banker on 3 stands.
      reset_and_deal4();
      repeat (3) add(1'b0, 1'b0, 4'd4, 4'd3);
      x_p3 = 4'd8; add(1'b0, 1'b1, 4'd4, 4'd3);
      add(1'b0, 1'b1, 4'd2, 4'd3);
      x_bw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd2, 4'd3);

      // Player stands on 6, banker on 5 draws counter value 5 -> banker total 0.
      reset_and_deal4();
      x_b3 = 4'd5; add(1'b0, 1'b1, 4'd6, 4'd5);
      x_pw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd6, 4'd0);

      // Tie 7-7, then five steps in DONE with different scores: nothing moves.
      reset_and_deal4();
      add(1'b0, 1'b1, 4'd7, 4'd7);
      x_pw = 1'b1; x_bw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd7, 4'd7);
      repeat (5) add(1'b0, 1'b1, 4'd2, 4'd9);

      // Reset after pcard2: next step reloads pcard1, not bcard2.
      clr();
      add(1'b1, 1'b0, 4'd0, 4'd0);
      x_p1 = 4'd1; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_b1 = 4'd2; add(1'b0, 1'b1, 4'd0, 4'd0);
      x_p2 = 4'd3; add(1'b0, 1'b1, 4'd0, 4'd0);
      clr();
      add(1'b1, 1'b0, 4'd0, 4'd0);
      x_p1 = 4'd1; add(1'b0, 1'b1, 4'd0, 4'd0);
      add(1'b0, 1'b0, 4'd0, 4'd0);

      // Player draws 5, banker on 4 holds a cycle in BANK3, then draws a 7.
      reset_and_deal4();
      x_p3 = 4'd5; add(1'b0, 1'b1, 4'd3, 4'd4);
      add(1'b0, 1'b0, 4'd8, 4'd4);
      x_b3 = 4'd7; add(1'b0, 1'b1, 4'd8, 4'd4);
      x_pw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd8, 4'd1);

      // Player draws a K (counter 13, value 0); banker on 3 draws the wrapped 1.
      reset_and_deal4();
      repeat (8) add(1'b0, 1'b0, 4'd2, 4'd6);
      x_p3 = 4'd13; add(1'b0, 1'b1, 4'd2, 4'd6);
      x_b3 = 4'd1;  add(1'b0, 1'b1, 4'd2, 4'd3);
      x_bw = 1'b1; x_dn = 1'b1;
      add(1'b0, 1'b0, 4'd2, 4'd4);

      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].rst, vecs[i].stp, vecs[i].ps, vecs[i].bs);
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp_out));
      end

      // Result latency: done must be low right after the RESULT-entry edge and rise one clock later.
      tick(1'b1, 1'b0, 4'd0, 4'd0);
      repeat (4) tick(1'b0, 1'b1, 4'd0, 4'd0);
      tick(1'b0, 1'b1, 4'd9, 4'd9);
      check("done_low_in_result", 32'(done), 32'd0);
      lat = 0;
      while (done !== 1'b1 && lat < 6) begin
         tick(1'b0, 1'b0, 4'd9, 4'd9);
         lat++;
      end
      check("done_latency", lat, 32'd1);
      check("tie_flags", 32'({player_win, banker_win}), 32'd3);
      check("natural_no_draw", 32'({pcard3, bcard3}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/baccarat_dealer.md
# baccarat_dealer

Deal sequencer for one baccarat hand. It draws card ranks from a free-running 1–13 counter and loads them, one per `step`, into six card registers in baccarat order: P1, B1, P2, B2, then optional third cards. It applies the player and banker third-card rules using hand scores fed back from two external `scorehand` instances, and latches the winner. It sits upstream of the scorehand instances, which consume its card registers, and upstream of the card/score display logic.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; every register is in this domain.
- `reset`  in  1  synchronous, active-high; clears the hand and the counter.
- `step`  in  1  advance request, sampled every `clk`; each high cycle is one step.
- `pscore`  in  4  player hand total 0–9 from the player `scorehand`, driven by `pcard1..3`.
- `bscore`  in  4  banker hand total 0–9 from the banker `scorehand`, driven by `bcard1..3`.
- `pcard1`, `pcard2`, `pcard3`  out  4 each  player card ranks; 0 = no card, 1–13 = A..K.
- `bcard1`, `bcard2`, `bcard3`  out  4 each  banker card ranks, same encoding.
- `player_win`  out  1  player won; also high on a tie.
- `banker_win`  out  1  banker won; also high on a tie.
- `done`  out  1  hand complete and result latched.

## Operation
- **Card counter.** Runs 1→2→…→13→1 every `clk`, independent of state. A load writes the counter's value at that clock edge.
- **Rank value.** Used only for the banker rule: ranks 1–9 map to 1–9; ranks 10–13 map to 0.
- **States and transitions** (a "step" is a cycle with `step`=1):
  - DEAL_P1: step → load `pcard1` → DEAL_B1.
  - DEAL_B1: step → load `bcard1` → DEAL_P2.
  - DEAL_P2: step → load `pcard2` → DEAL_B2.
  - DEAL_B2: step → load `bcard2` → DECIDE.
  - DECIDE, on step:
    - Natural: `pscore`≥8 or `bscore`≥8 → RESULT, no load.
    - Player draws: `pscore`≤5 → load `pcard3` → BANK3.
    - Player stands (6–7): if `bscore`≤5, load `bcard3`; either way → RESULT.
  - BANK3, on step: let v = value(`pcard3`). Banker draws (load `bcard3`) when any of:
    - `bscore`≤2;
    - `bscore`=3 and v≠8;
    - `bscore`=4 and v∈2..7;
    - `bscore`=5 and v∈4..7;
    - `bscore`=6 and v∈6..7.
    - Otherwise no draw. Next state is RESULT in both cases.
  - RESULT: automatic, no step needed. Latch `player_win`=(`pscore`≥`bscore`) and `banker_win`=(`bscore`≥`pscore`); set `done`=1 → DONE.
  - DONE: terminal. `step` is ignored; only `reset` starts a new hand.
- **Step outside decision points.** In DEAL_* and DECIDE/BANK3, a cycle without `step` holds state and all registers. In RESULT, `step` is ignored.
- **Reset** (any state, including mid-deal) takes priority over `step`:
  - state → DEAL_P1, counter → 1;
  - all six cards → 0;
  - `player_win`, `banker_win`, `done` → 0.

## Timing
- Each load is visible on its card output the cycle after the step edge.
- `pscore`/`bscore` are combinational from the card registers, so they are valid before the next edge. Back-to-back steps are therefore legal.
- **Latency**, from the step edge that enters RESULT:
  - winner flags and `done` rise one `clk` later;
  - they stay stable until `reset`.
- Card outputs never change in RESULT or DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- `baccarat_pkg` holds:
  - state enum `deal_state_t`;
  - constants `CARD_NONE`=0, `CARD_MIN`=1, `CARD_MAX`=13;
  - function `card_value(rank)` returning 0–9. The scorehand logic shares this function.
- Sub-module `card_counter` (`clk`, `reset`, 4-bit `card` output): the 1–13 wrap counter.
- Everything else — the FSM, card registers, and result flags — lives in `baccarat_dealer`.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-stream. Expect all cards 0, `done`=`player_win`=`banker_win`=0, counter=1, and the first step after release loads `pcard1` with the counter value at that edge.
- **Natural:** deal four cards, drive `pscore`=8, `bscore`=3, step in DECIDE. Expect `pcard3`=`bcard3`=0; one cycle after RESULT, `player_win`=1, `banker_win`=0, `done`=1.
- **Player draws, banker stands:** `pscore`=4 in DECIDE, with the step timed so `pcard3`=8. In BANK3 drive `bscore`=3 and step. Expect `bcard3`=0 and `done`=1 one cycle after RESULT.
- **Player stands, banker draws:** `pscore`=6, `bscore`=5, step in DECIDE. Expect `bcard3` = counter value at the edge, `pcard3`=0, then RESULT.
- **Tie:** final `pscore`=`bscore`=7. Expect `player_win`=`banker_win`=1. Then pulse `step` 5 times in DONE; all outputs are unchanged.
- **Reset mid-deal:** after the `pcard2` load, assert `reset` for 1 cycle. Expect all cards 0, and the next step loads `pcard1`, not `bcard2`.
